fmul_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point multiplier with a valid/ready handshake. It generalises the single-precision combinational multiplier in three ways: exponent and mantissa widths are set by parameters, the datapath has three registered stages, and the block handles rounding modes, special values and exception flags. It sits in the FPU between issue and writeback, and back-pressure from writeback stalls the whole pipe.

---
 rtl/fmul_pipe_pkg.sv | 22 ++
 rtl/fmul_pipe_if.sv | 11 +
 rtl/fmul_pipe_fround.sv | 30 +++
 rtl/fmul_pipe.sv | 121 ++++++++++++
 tb/tb_fmul_pipe.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fmul_pipe_pkg.sv
// fpu_pkg: operand classes, rounding modes, flag layout and format constants for fmul_pipe
package fpu_pkg;
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fclass_t;
  typedef enum logic {RNE = 1'b0, RTZ = 1'b1} rmode_t;
  localparam int FL_INV = 3;
  localparam int FL_OVF = 2;
  localparam int FL_UNF = 1;
  localparam int FL_INX = 0;
  localparam logic [3:0] F_INV = 4'b1 << FL_INV;
  localparam logic [3:0] F_OVF = 4'b1 << FL_OVF;
  localparam logic [3:0] F_UNF = 4'b1 << FL_UNF;
  localparam logic [3:0] F_INX = 4'b1 << FL_INX;
  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
  function automatic logic [63:0] qnan(input int ew, input int mw);
    return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
  endfunction
  function automatic logic [63:0] max_finite(input int ew, input int mw);
    return (((64'd1 << ew) - 64'd2) << mw) | ((64'd1 << mw) - 64'd1);
  endfunction
endpackage

// File: rtl/fmul_pipe_if.sv
// fmul_pipe_if: operand/result handshake bundle for fmul_pipe
//   request:  in_valid, in_ready, x1, x2, rm
//   response: out_valid, out_ready, y, flags {invalid, overflow, underflow, inexact}
interface fmul_pipe_if #(parameter int EW = 8, parameter int MW = 23);
  localparam int W = EW + MW + 1;
  logic in_valid, in_ready, rm, out_valid, out_ready;
  logic [W-1:0] x1, x2, y;
  logic [3:0] flags;
  modport master (output in_valid, x1, x2, rm, out_ready, input in_ready, out_valid, y, flags);
  modport slave (input in_valid, x1, x2, rm, out_ready, output in_ready, out_valid, y, flags);
endinterface

// File: rtl/fmul_pipe_fround.sv
// fround: normalise a {1,m1}x{1,m2} product and round it to MW bits
//   prod: raw product; rm: rounding mode
//   mant: rounded mantissa; exp_inc: normalise shift plus rounding carry; inexact: G|R|S
module fround
  import fpu_pkg::*;
#(
  parameter int MW = 23
) (
  input  logic [2*MW+1:0] prod,
  input  rmode_t          rm,
  output logic [MW-1:0]   mant,
  output logic [1:0]      exp_inc,
  output logic            inexact
);
  logic [MW-1:0] m;
  logic [MW:0] sum;
  logic hi, g, r, s, up;
  always_comb begin
    hi = prod[2*MW+1];
    m = hi ? prod[2*MW:MW+1] : prod[2*MW-1:MW];
    g = hi ? prod[MW] : prod[MW-1];
    r = hi ? prod[MW-1] : prod[MW-2];
    s = hi ? |prod[MW-2:0] : |prod[MW-3:0];
    up = (rm == RNE) & g & (r | s | m[0]);
    sum = {1'b0, m} + (MW+1)'(up);
    mant = sum[MW-1:0];
    exp_inc = {1'b0, hi} + {1'b0, sum[MW]};
    inexact = g | r | s;
  end
endmodule

// File: rtl/fmul_pipe.sv
// fmul_pipe: 3-stage floating-point multiplier with valid/ready back-pressure
//   clk, rstn (async active-low); bus: fmul_pipe_if.slave
//   S1 unpack/classify/multiply, S2 normalise/round, S3 range check/specials/flags (output regs)
module fmul_pipe
  import fpu_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input logic         clk,
  input logic         rstn,
  fmul_pipe_if.slave  bus
);
  localparam int W = EW + MW + 1;
  localparam int PW = 2 * MW + 2;
  localparam logic [63:0] QNAN64 = qnan(EW, MW);
  localparam logic [63:0] MAXF64 = max_finite(EW, MW);
  localparam logic [EW+1:0] BIAS = (EW+2)'(bias(EW));
  localparam logic [EW+1:0] EMAX = (EW+2)'((1 << EW) - 1);
  typedef struct packed {
    logic s;
    fclass_t c1, c2;
    rmode_t rm;
    logic [EW+1:0] e;
    logic [PW-1:0] p;
  } s1_t;
  typedef struct packed {
    logic s;
    fclass_t c1, c2;
    rmode_t rm;
    logic [EW+1:0] e;
    logic [MW-1:0] m;
    logic inx;
  } s2_t;
  function automatic fclass_t cls(input logic [W-1:0] x);
    return x[W-2:MW] == '0 ? ZERO : (x[W-2:MW] != '1 ? NORM : (x[MW-1:0] == '0 ? INF : NAN));
  endfunction
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic v1, v2, adv;
  logic [MW-1:0] rmant;
  logic [1:0] einc;
  logic rinx, nan_in, inf_in, zero_in, ovf, unf;
  logic [W-1:0] y_d;
  logic [3:0] f_d;
  assign adv = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;
  // exponent kept in EW+2 bits two's complement so underflow shows up as a negative sum
  always_comb begin
    s1_d.s = bus.x1[W-1] ^ bus.x2[W-1];
    s1_d.c1 = cls(bus.x1);
    s1_d.c2 = cls(bus.x2);
    s1_d.rm = rmode_t'(bus.rm);
    s1_d.e = (EW+2)'(bus.x1[W-2:MW]) + (EW+2)'(bus.x2[W-2:MW]) - BIAS;
    s1_d.p = PW'({1'b1, bus.x1[MW-1:0]}) * PW'({1'b1, bus.x2[MW-1:0]});
  end
  fround #(.MW(MW)) u_round (
    .prod    (s1_q.p),
    .rm      (s1_q.rm),
    .mant    (rmant),
    .exp_inc (einc),
    .inexact (rinx)
  );
  always_comb begin
    s2_d.s = s1_q.s;
    s2_d.c1 = s1_q.c1;
    s2_d.c2 = s1_q.c2;
    s2_d.rm = s1_q.rm;
    s2_d.e = s1_q.e + (EW+2)'(einc);
    s2_d.m = rmant;
    s2_d.inx = rinx;
  end
  always_comb begin
    nan_in = s2_q.c1 == NAN || s2_q.c2 == NAN;
    inf_in = s2_q.c1 == INF || s2_q.c2 == INF;
    zero_in = s2_q.c1 == ZERO || s2_q.c2 == ZERO;
    ovf = !s2_q.e[EW+1] && s2_q.e >= EMAX;
    unf = s2_q.e[EW+1] || s2_q.e == '0;
    y_d = {s2_q.s, s2_q.e[EW-1:0], s2_q.m};
    f_d = s2_q.inx ? F_INX : 4'b0;
    if (nan_in) begin
      y_d = QNAN64[W-1:0];
      f_d = '0;
    end else if (inf_in && zero_in) begin
      y_d = QNAN64[W-1:0];
      f_d = F_INV;
    end else if (inf_in) begin
      y_d = {s2_q.s, {EW{1'b1}}, {MW{1'b0}}};
      f_d = '0;
    end else if (zero_in) begin
      y_d = {s2_q.s, {(W-1){1'b0}}};
      f_d = '0;
    end else if (ovf) begin
      y_d = s2_q.rm == RNE ? {s2_q.s, {EW{1'b1}}, {MW{1'b0}}} : {s2_q.s, MAXF64[W-2:0]};
      f_d = F_OVF | F_INX;
    end else if (unf) begin
      y_d = {s2_q.s, {(W-1){1'b0}}};
      f_d = F_UNF | F_INX;
    end
  end
  // the whole pipe, bubbles included, moves only when the output slot is free
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      bus.out_valid <= 1'b0;
      bus.y <= '0;
      bus.flags <= '0;
    end else if (adv) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      s1_q <= s1_d;
      s2_q <= s2_d;
      bus.out_valid <= v2;
      bus.y <= y_d;
      bus.flags <= f_d;
    end
  end
endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: scoreboard bench for fmul_pipe (single precision and EW=5/MW=10 instances)
module tb_fmul_pipe;
  typedef struct {
    logic [31:0] y;
    logic [3:0] f;
    int cyc;
    bit lat;
    string name;
  } exp_t;
  logic clk = 0;
  logic rstn = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  exp_t q[$];
  exp_t hq[$];
  exp_t me, mh;
  fmul_pipe_if #(.EW(8), .MW(23)) sif ();
  fmul_pipe_if #(.EW(5), .MW(10)) hif ();
  fmul_pipe #(.EW(8), .MW(23)) dut (.clk(clk), .rstn(rstn), .bus(sif));
  fmul_pipe #(.EW(5), .MW(10)) dut_h (.clk(clk), .rstn(rstn), .bus(hif));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask
  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: event did not occur as required", name);
  endtask
  always @(negedge clk) begin
    if (rstn && sif.out_valid && sif.out_ready) begin
      if (q.size() == 0) fail("sp_unexpected_output");
      else begin
        me = q.pop_front();
        check({me.name, "_y"}, sif.y, me.y);
        check({me.name, "_flags"}, sif.flags, me.f);
        if (me.lat) check({me.name, "_latency"}, cyc - me.cyc, 3);
      end
    end
    if (rstn && hif.out_valid && hif.out_ready) begin
      if (hq.size() == 0) fail("hp_unexpected_output");
      else begin
        mh = hq.pop_front();
        check({mh.name, "_y"}, hif.y, mh.y);
        check({mh.name, "_flags"}, hif.flags, mh.f);
      end
    end
  end
  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b, input logic r,
                       input logic [31:0] ey, input logic [3:0] ef, input bit lat);
    exp_t e;
    @(posedge clk);
    #1;
    sif.in_valid = 1;
    sif.x1 = a;
    sif.x2 = b;
    sif.rm = r;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sif.in_ready) begin
        e.y = ey;
        e.f = ef;
        e.cyc = cyc;
        e.lat = lat;
        e.name = name;
        q.push_back(e);
        return;
      end
      @(posedge clk);
      #1;
    end
    fail({name, "_accept_timeout"});
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
    sif.in_valid = 0;
  endtask
  task automatic hissue(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ey, input logic [3:0] ef);
    exp_t e;
    @(posedge clk);
    #1;
    hif.in_valid = 1;
    hif.x1 = a;
    hif.x2 = b;
    hif.rm = 0;
    @(negedge clk);
    if (hif.in_ready) begin
      e.y = {16'h0, ey};
      e.f = ef;
      e.cyc = cyc;
      e.lat = 0;
      e.name = name;
      hq.push_back(e);
    end else fail({name, "_not_accepted"});
    @(posedge clk);
    #1;
    hif.in_valid = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && (q.size() != 0 || hq.size() != 0); i++) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    sif.in_valid = 0; sif.x1 = 0; sif.x2 = 0; sif.rm = 0; sif.out_ready = 1;
    hif.in_valid = 0; hif.x1 = 0; hif.x2 = 0; hif.rm = 0; hif.out_ready = 1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", sif.out_valid, 0);
    check("rst_y", sif.y, 0);
    check("rst_flags", sif.flags, 0);
    check("rst_in_ready", sif.in_ready, 1);
    rstn = 1;
    issue("mul_1p5x2", 32'h3FC00000, 32'h40000000, 0, 32'h40400000, 4'b0000, 1);
    idle();
    drain();
    issue("tie_rne", 32'h3F800001, 32'h3FC00000, 0, 32'h3FC00002, 4'b0001, 0);
    issue("tie_rtz", 32'h3F800001, 32'h3FC00000, 1, 32'h3FC00001, 4'b0001, 0);
    issue("ovf_rne", 32'h7F000000, 32'h40000000, 0, 32'h7F800000, 4'b0101, 0);
    issue("ovf_rtz", 32'h7F000000, 32'h40000000, 1, 32'h7F7FFFFF, 4'b0101, 0);
    issue("unf", 32'h00800000, 32'h3F000000, 0, 32'h00000000, 4'b0011, 0);
    issue("inf_x_zero", 32'h7F800000, 32'h00000000, 0, 32'h7FC00000, 4'b1000, 0);
    issue("neg_inf", 32'hFF800000, 32'h40000000, 0, 32'hFF800000, 4'b0000, 0);
    issue("nan_in", 32'h7FC00001, 32'h3F800000, 0, 32'h7FC00000, 4'b0000, 0);
    issue("neg_zero", 32'h80000000, 32'h3F800000, 0, 32'h80000000, 4'b0000, 0);
    idle();
    drain();
    @(posedge clk);
    #1;
    sif.out_ready = 0;
    fork
      begin
        issue("bp0", 32'h3FC00000, 32'h40000000, 0, 32'h40400000, 4'b0000, 0);
        issue("bp1", 32'h40000000, 32'h40000000, 0, 32'h40800000, 4'b0000, 0);
        issue("bp2", 32'h3F800000, 32'h3F800000, 0, 32'h3F800000, 4'b0000, 0);
        issue("bp3", 32'h40400000, 32'h40000000, 0, 32'h40C00000, 4'b0000, 0);
        issue("bp4", 32'hBF800000, 32'h40000000, 0, 32'hC0000000, 4'b0000, 0);
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        check("bp_out_valid_held", sif.out_valid, 1);
        check("bp_in_ready_low", sif.in_ready, 0);
        check("bp_y_held_a", sif.y, 32'h40400000);
        repeat (3) @(negedge clk);
        check("bp_y_held_b", sif.y, 32'h40400000);
        check("bp_flags_held", sif.flags, 0);
        @(posedge clk);
        #1;
        sif.out_ready = 1;
      end
    join
    drain();
    check("bp_all_drained", q.size(), 0);
    @(posedge clk);
    #1;
    sif.out_ready = 0;
    hif.out_ready = 0;
    fork
      begin
        issue("rst_a", 32'h3FC00000, 32'h40000000, 0, 32'h40400000, 4'b0000, 0);
        issue("rst_b", 32'h40000000, 32'h40000000, 0, 32'h40800000, 4'b0000, 0);
        issue("rst_c", 32'h3F800000, 32'h3F800000, 0, 32'h3F800000, 4'b0000, 0);
      end
      hissue("hp_rst", 16'h3C00, 16'h4000, 16'h4000, 4'b0000);
    join
    @(negedge clk);
    check("pre_rst_out_valid", sif.out_valid, 1);
    #2;
    rstn = 0;
    sif.in_valid = 0;
    hif.in_valid = 0;
    #1;
    check("mid_rst_out_valid", sif.out_valid, 0);
    check("mid_rst_in_ready", sif.in_ready, 1);
    check("mid_rst_hp_out_valid", hif.out_valid, 0);
    q.delete();
    hq.delete();
    sif.out_ready = 1;
    hif.out_ready = 1;
    repeat (2) @(negedge clk);
    rstn = 1;
    repeat (10) @(negedge clk);
    check("post_rst_in_ready", sif.in_ready, 1);
    hissue("hp_1x2", 16'h3C00, 16'h4000, 16'h4000, 4'b0000);
    hissue("hp_1p5x2", 16'h3E00, 16'h4000, 16'h4200, 4'b0000);
    hissue("hp_ovf", 16'h7800, 16'h4000, 16'h7C00, 4'b0101);
    issue("post_rst_sp", 32'h40400000, 32'h40000000, 0, 32'h40C00000, 4'b0000, 1);
    idle();
    drain();
    check("leftover_expected", q.size() + hq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
